// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
// Contents:
//   nibble_t    - one hex digit
//   SEG_OFF     - all segments dark (active-low pattern gfedcba)
//   GLYPH_TABLE - hex glyphs indexed by nibble, gfedcba, 0 = lit
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH_TABLE [0:15] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1011000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex-nibble to seven-segment glyph decoder.
// Ports:
//   nibble - hex digit to display
//   glyph  - segment pattern gfedcba, active-low
module seg7_glyph
  import seg7_pkg::*;
(
  input  nibble_t    nibble,
  output logic [6:0] glyph
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    glyph = GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment display scanner with frame-synchronous
// display updates, leading-zero suppression and inter-digit ghost blanking.
// Ports:
//   CLK        - clock, all state on rising edge
//   RESET      - synchronous active-high reset
//   VALUE      - hex nibbles, digit 0 in VALUE[3:0] (rightmost)
//   DP         - decimal point request per digit (1 = lit)
//   BLANK      - force digit dark (1 = dark)
//   LOAD       - capture VALUE/DP/BLANK into the pending register
//   SEG        - segments gfedcba, active-low
//   DP_N       - decimal point, active-low
//   DIG_N      - digit enables, active-low, at most one low
//   FRAME_DONE - one-cycle pulse after each full scan
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int GHOST_CYC   = 2,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   BLANK,
  input  logic                    LOAD,
  output logic [6:0]              SEG,
  output logic                    DP_N,
  output logic [NUM_DIGITS-1:0]   DIG_N,
  output logic                    FRAME_DONE
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GHOST_LIM = DIV_W'(GHOST_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] disp_val_r, pend_val_r;
  logic [NUM_DIGITS-1:0]   disp_dp_r, pend_dp_r;
  logic [NUM_DIGITS-1:0]   disp_blank_r, pend_blank_r;
  logic                    pend_valid_r;
  logic [6:0]              seg_r;
  logic                    dp_n_r;
  logic [NUM_DIGITS-1:0]   dig_n_r;
  logic                    frame_done_r;

  logic                    slot_end_s;
  logic                    frame_wrap_s;
  logic                    ghost_s;
  nibble_t                 cur_nib_s;
  logic                    cur_dp_s;
  logic                    cur_blank_s;
  logic                    cur_lz_s;
  logic                    zero_run_s;
  logic [NUM_DIGITS-1:0]   lz_dark_s;
  logic [NUM_DIGITS-1:0]   dig_sel_n_s;
  logic [6:0]              glyph_s;
  logic [6:0]              seg_s;
  logic                    dp_n_s;
  logic [NUM_DIGITS-1:0]   dig_n_s;

  assign slot_end_s   = (div_r == DIV_LAST);
  assign frame_wrap_s = slot_end_s && (idx_r == IDX_LAST);
  assign ghost_s      = (div_r < GHOST_LIM);

  // Slot divider and digit index
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_r <= '0;
      idx_r <= '0;
    end else if (slot_end_s) begin
      div_r <= '0;
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Pending and display registers; display only changes at the frame boundary
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_val_r   <= '0;
      pend_dp_r    <= '0;
      pend_blank_r <= '0;
      pend_valid_r <= 1'b0;
      disp_val_r   <= '0;
      disp_dp_r    <= '0;
      disp_blank_r <= '0;
    end else begin
      // A LOAD on the boundary cycle refills pending after the old contents move out
      if (LOAD) begin
        pend_val_r   <= VALUE;
        pend_dp_r    <= DP;
        pend_blank_r <= BLANK;
        pend_valid_r <= 1'b1;
      end else if (frame_wrap_s) begin
        pend_valid_r <= 1'b0;
      end
      if (frame_wrap_s && pend_valid_r) begin
        disp_val_r   <= pend_val_r;
        disp_dp_r    <= pend_dp_r;
        disp_blank_r <= pend_blank_r;
      end
    end
  end

  // Leading-zero mask and current-digit selection
  always_comb begin
    zero_run_s  = 1'b1;
    lz_dark_s   = '0;
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b0;
    cur_lz_s    = 1'b0;
    dig_sel_n_s = {NUM_DIGITS{1'b1}};
    // Walk from the most significant digit; a digit is suppressible while all above it are zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (disp_val_r[4*i +: 4] == 4'h0);
      if ((i > 0) && (LZ_SUPPRESS != 0)) begin
        lz_dark_s[i] = zero_run_s;
      end else begin
        lz_dark_s[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_r == i[IDX_W-1:0]) begin
        cur_nib_s      = disp_val_r[4*i +: 4];
        cur_dp_s       = disp_dp_r[i];
        cur_blank_s    = disp_blank_r[i];
        cur_lz_s       = lz_dark_s[i];
        dig_sel_n_s[i] = 1'b0;
      end else begin
        dig_sel_n_s[i] = 1'b1;
      end
    end
  end

  seg7_glyph u_glyph (
    .nibble (cur_nib_s),
    .glyph  (glyph_s)
  );

  // Next output values; ghost cycles darken everything to hide digit-switch smear
  always_comb begin
    seg_s   = SEG_OFF;
    dp_n_s  = 1'b1;
    dig_n_s = {NUM_DIGITS{1'b1}};
    if (ghost_s) begin
      seg_s   = SEG_OFF;
      dp_n_s  = 1'b1;
      dig_n_s = {NUM_DIGITS{1'b1}};
    end else begin
      dig_n_s = dig_sel_n_s;
      seg_s   = (cur_blank_s || cur_lz_s) ? SEG_OFF : glyph_s;
      // A suppressed digit still shows its decimal point; a blanked one does not
      dp_n_s  = cur_blank_s ? 1'b1 : ~cur_dp_s;
    end
  end

  // Registered display outputs and frame pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      seg_r        <= SEG_OFF;
      dp_n_r       <= 1'b1;
      dig_n_r      <= {NUM_DIGITS{1'b1}};
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_s;
      dp_n_r       <= dp_n_s;
      dig_n_r      <= dig_n_s;
      frame_done_r <= frame_wrap_s;
    end
  end

  assign SEG        = seg_r;
  assign DP_N       = dp_n_r;
  assign DIG_N      = dig_n_r;
  assign FRAME_DONE = frame_done_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with NUM_DIGITS=4, SCAN_DIV=4, GHOST_CYC=1.
// Two instances share stimulus: one with leading-zero suppression, one without.
module tb_seg7_scan;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] VALUE;
  logic [3:0]  DP;
  logic [3:0]  BLANK;
  logic        LOAD;

  logic [6:0]  seg_a, seg_b;
  logic        dp_n_a, dp_n_b;
  logic [3:0]  dig_n_a, dig_n_b;
  logic        fd_a, fd_b;

  int errors = 0;
  int checks = 0;
  int m = 0;  // clock edges since reset released

  // Expected display register contents for the frame being scanned
  logic [15:0] d_val;
  logic [3:0]  d_dp;
  logic [3:0]  d_blank;

  logic [6:0] glyph_ref [0:15];

  always #5 CLK = ~CLK;

  seg7_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .GHOST_CYC(1), .LZ_SUPPRESS(1)) dut (
    .CLK(CLK), .RESET(RESET), .VALUE(VALUE), .DP(DP), .BLANK(BLANK), .LOAD(LOAD),
    .SEG(seg_a), .DP_N(dp_n_a), .DIG_N(dig_n_a), .FRAME_DONE(fd_a)
  );

  seg7_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .GHOST_CYC(1), .LZ_SUPPRESS(0)) dut_nolz (
    .CLK(CLK), .RESET(RESET), .VALUE(VALUE), .DP(DP), .BLANK(BLANK), .LOAD(LOAD),
    .SEG(seg_b), .DP_N(dp_n_b), .DIG_N(dig_n_b), .FRAME_DONE(fd_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s m=%0d observed=%h expected=%h", tag, m, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    if (RESET) m = 0;
    else m++;
  endtask

  task automatic check_off;
    chk("rst_seg_a",  {9'h0, seg_a},    16'h007F);
    chk("rst_dpn_a",  {15'h0, dp_n_a},  16'h0001);
    chk("rst_dig_a",  {12'h0, dig_n_a}, 16'h000F);
    chk("rst_fd_a",   {15'h0, fd_a},    16'h0000);
    chk("rst_seg_b",  {9'h0, seg_b},    16'h007F);
    chk("rst_dig_b",  {12'h0, dig_n_b}, 16'h000F);
    chk("rst_fd_b",   {15'h0, fd_b},    16'h0000);
  endtask

  // Outputs after edge m reflect scan position m-1
  task automatic check_cycle;
    int c, dv, ix;
    bit ghost, blk, lzd;
    logic [6:0] g, e_lz, e_nolz;
    logic e_dp;
    logic [3:0] e_dig;
    logic e_fd;
    c     = m - 1;
    dv    = c % 4;
    ix    = (c / 4) % 4;
    ghost = (dv == 0);
    blk   = d_blank[ix];
    lzd   = (ix > 0) && ((d_val >> (4 * ix)) == 16'h0000);
    g     = glyph_ref[d_val[4*ix +: 4]];
    e_lz   = (ghost || blk || lzd) ? 7'h7F : g;
    e_nolz = (ghost || blk) ? 7'h7F : g;
    e_dp   = (ghost || blk) ? 1'b1 : ~d_dp[ix];
    e_dig  = ghost ? 4'hF : ~(4'b0001 << ix);
    e_fd   = ((m % 16) == 0);
    chk("seg_a", {9'h0, seg_a},    {9'h0, e_lz});
    chk("dpn_a", {15'h0, dp_n_a},  {15'h0, e_dp});
    chk("dig_a", {12'h0, dig_n_a}, {12'h0, e_dig});
    chk("fd_a",  {15'h0, fd_a},    {15'h0, e_fd});
    chk("seg_b", {9'h0, seg_b},    {9'h0, e_nolz});
    chk("dpn_b", {15'h0, dp_n_b},  {15'h0, e_dp});
    chk("dig_b", {12'h0, dig_n_b}, {12'h0, e_dig});
  endtask

  // Run n edges, optionally pulsing LOAD before edge la and/or edge lb
  task automatic run(input int n,
                     input int la, input logic [15:0] va, input logic [3:0] da, input logic [3:0] ba,
                     input int lb, input logic [15:0] vb, input logic [3:0] db, input logic [3:0] bb);
    for (int i = 1; i <= n; i++) begin
      if (i == la) begin
        LOAD = 1'b1; VALUE = va; DP = da; BLANK = ba;
      end else if (i == lb) begin
        LOAD = 1'b1; VALUE = vb; DP = db; BLANK = bb;
      end else begin
        LOAD = 1'b0;
      end
      tick();
      check_cycle();
    end
    LOAD = 1'b0;
  endtask

  initial begin
    glyph_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    RESET = 1'b1; LOAD = 1'b0; VALUE = 16'h0000; DP = 4'h0; BLANK = 4'h0;
    d_val = 16'h0000; d_dp = 4'h0; d_blank = 4'h0;

    // Reset state
    tick(); check_off();
    tick(); check_off();
    RESET = 1'b0;

    // Frame 0: blank display, digit 0 shows '0'
    run(16, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    // Frame 1: mid-frame load must not tear
    run(16, 5, 16'h12AF, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    // Frame 2: 12AF visible
    d_val = 16'h12AF;
    run(16, 3, 16'h0050, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    // Frame 3: 0050, leading zeros suppressed only on the LZ instance
    d_val = 16'h0050;
    run(16, 10, 16'h0050, 4'b0100, 4'b0010, -1, 16'h0, 4'h0, 4'h0);
    // Frame 4: DP on suppressed digit 2, digit 1 blanked; second load on boundary
    d_dp = 4'b0100; d_blank = 4'b0010;
    run(16, 2, 16'h1111, 4'h0, 4'h0, 16, 16'h2222, 4'h0, 4'h0);
    // Frame 5: first load wins this frame
    d_val = 16'h1111; d_dp = 4'h0; d_blank = 4'h0;
    run(16, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    // Frame 6: boundary load appears one frame later
    d_val = 16'h2222;
    run(16, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    // Frame 7: load pending, then reset inside the digit 2 slot
    run(9, 2, 16'h1234, 4'hF, 4'h0, -1, 16'h0, 4'h0, 4'h0);
    RESET = 1'b1;
    tick(); check_off();
    RESET = 1'b0;
    d_val = 16'h0000; d_dp = 4'h0; d_blank = 4'h0;
    // Scan restarts at digit 0 and the discarded pending never appears
    run(32, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
